// File: rtl/rv32i_mem_unit.sv
// RV32I memory stage: single-outstanding bus access with byte lanes, load extension and ack timeout.
// Optional build macro MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module rv32i_mem_unit #(
    parameter int unsigned IO_SEL_BIT = 31,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_reg_in,
    output logic        out_valid,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic        wb_en_out,
    output logic [4:0]  wb_reg_out,
    output logic [31:0] wb_data_out,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_io,
    output logic [3:0]  bus_be,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        err_out
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned CNT_W  = 8;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_valid, r_err, r_wb_en, r_wb_en_hold;
    logic [XLEN-1:0]   r_pc, r_iw, r_wb_data, r_bus_wdata;
    logic [4:0]        r_wb_reg;
    logic              r_bus_req, r_bus_we, r_bus_io;
    logic [3:0]        r_bus_be;
    logic [29:0]       r_bus_addr;
    logic [2:0]        r_f3;
    logic [1:0]        r_lo;

    logic              w_accept, w_is_load, w_is_store, w_is_mem, w_misalign;
    logic              w_start, w_direct, w_ack, w_timeout;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;

    assign in_ready   = (r_state == ST_IDLE) && !reset;
    assign w_accept   = in_valid && in_ready;
    assign w_is_load  = (iw_in[6:0] == OP_LOAD);
    assign w_is_store = (iw_in[6:0] == OP_STORE);
    assign w_is_mem   = w_is_load || w_is_store;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = w_is_mem && (((iw_in[13:12] == 2'b01) && alu_in[0]) ||
                                     (iw_in[13] && (alu_in[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    // funct3[1:0] selects access size: 00 byte, 01 half, otherwise word
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2_data_in;
        case (iw_in[13:12])
            2'b00: begin
                w_be    = 4'b0001 << alu_in[1:0];
                w_wdata = {4{rs2_data_in[7:0]}};
            end
            2'b01: begin
                w_be    = alu_in[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rs2_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d,
                                                 input logic [1:0] lo,
                                                 input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lo[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_direct    = 1'b0;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_mem && !w_misalign) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_direct    = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: bus fields are captured at accept and held until ack or timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_wb_en      <= 1'b0;
            r_wb_en_hold <= 1'b0;
            r_pc         <= '0;
            r_iw         <= '0;
            r_wb_data    <= '0;
            r_wb_reg     <= '0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_io     <= 1'b0;
            r_bus_be     <= '0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_f3         <= '0;
            r_lo         <= '0;
        end else begin
            r_out_valid <= w_direct || w_ack || w_timeout;
            r_err       <= w_timeout || (w_direct && w_misalign);
            if (w_accept) begin
                r_pc     <= pc_in;
                r_iw     <= iw_in;
                r_wb_reg <= wb_reg_in;
            end
            if (w_direct) begin
                r_wb_en   <= wb_en_in && !w_misalign;
                r_wb_data <= alu_in;
            end
            if (w_start) begin
                r_bus_req    <= 1'b1;
                r_bus_we     <= w_is_store;
                r_bus_io     <= alu_in[IO_SEL_BIT];
                r_bus_addr   <= alu_in[31:2];
                r_bus_be     <= w_be;
                r_bus_wdata  <= w_wdata;
                r_f3         <= iw_in[14:12];
                r_lo         <= alu_in[1:0];
                r_wb_en_hold <= wb_en_in && !w_is_store;
                r_cnt        <= '0;
            end else if (w_ack) begin
                r_bus_req <= 1'b0;
                r_wb_en   <= r_wb_en_hold;
                r_wb_data <= r_bus_we ? {r_bus_addr, r_lo} : load_ext(bus_rdata, r_lo, r_f3);
            end else if (w_timeout) begin
                r_bus_req <= 1'b0;
                r_wb_en   <= 1'b0;
                r_wb_data <= {r_bus_addr, r_lo};
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign err_out     = r_err;
    assign pc_out      = r_pc;
    assign iw_out      = r_iw;
    assign wb_en_out   = r_wb_en;
    assign wb_reg_out  = r_wb_reg;
    assign wb_data_out = r_wb_data;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_io      = r_bus_io;
    assign bus_be      = r_bus_be;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
endmodule

// File: tb/tb_rv32i_mem_unit.sv
// Randomized bench for rv32i_mem_unit: transaction-level model sets per-cycle expectations
// that a negedge compare process checks; directed cases pin the model with literal values.
module tb_rv32i_mem_unit;
    localparam int unsigned MAXW = 15;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, wb_en_in, out_valid, wb_en_out;
    logic [31:0] pc_in, iw_in, alu_in, rs2_data_in, pc_out, iw_out, wb_data_out, bus_wdata, bus_rdata;
    logic [4:0] wb_reg_in, wb_reg_out;
    logic bus_req, bus_we, bus_io, bus_ack, err_out;
    logic [3:0] bus_be;
    logic [29:0] bus_addr;

    rv32i_mem_unit #(.IO_SEL_BIT(31), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in), .rs2_data_in(rs2_data_in),
        .wb_en_in(wb_en_in), .wb_reg_in(wb_reg_in), .out_valid(out_valid),
        .pc_out(pc_out), .iw_out(iw_out), .wb_en_out(wb_en_out), .wb_reg_out(wb_reg_out),
        .wb_data_out(wb_data_out), .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io),
        .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .err_out(err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, iw, alu, rs2;
        logic        wb_en;
        logic [4:0]  rd;
    } op_t;

    int checks = 0;
    int failures = 0;

    // Expectations for the current cycle (e_*) and for the cycle after the next edge (n_*)
    bit chk_en = 0, e_zero = 0, e_ready = 0, e_ov = 0, e_err = 0, e_wb_en = 0, e_chk_data = 0;
    bit e_req = 0, e_we = 0, e_io = 0;
    bit n_ov = 0, n_err = 0, n_wb_en = 0, n_chk_data = 0;
    logic [3:0]  e_be;
    logic [29:0] e_addr;
    logic [31:0] e_wdata, e_data, e_pc, e_iw, n_data, n_pc, n_iw;
    logic [4:0]  e_reg, n_reg;

    // Values observed on the DUT for the directed literal checks
    logic        cap_ov, cap_err, cap_wb_en, cap_req_after, cap_io, cap_we;
    logic [3:0]  cap_be;
    logic [29:0] cap_addr;
    logic [31:0] cap_wdata, cap_data;
    int          cap_req_cycles, cap_ready_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = m_size(f3);
        if (n == 1) return int'(a % 4);
        if (n == 2) return (a[1] ? 2 : 0);
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << m_size(f3)) - 1) << m_off(f3, a));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] w;
        int n;
        n = m_size(f3);
        w = '0;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = rs2[8*(b % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] d, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] mask, v;
        int n;
        n = m_size(f3);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v = (d >> (8 * m_off(f3, a))) & mask;
        if ((f3 == 3'b000 || f3 == 3'b001) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit m_misalign(input logic [2:0] f3, input logic [31:0] a);
        bit mis;
        mis = (m_size(f3) == 2 && a[0]) || (m_size(f3) == 4 && a[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
        return mis;
`else
        return mis & 1'b0;
`endif
    endfunction

    function automatic op_t mk_op(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [31:0] alu, input logic [31:0] rs2);
        op_t o;
        o.iw = $urandom;
        o.iw[6:0] = opc;
        o.iw[14:12] = f3;
        o.pc = $urandom & 32'hFFFF_FFFC;
        o.alu = alu;
        o.rs2 = rs2;
        o.wb_en = 1'b1;
        o.rd = 5'($urandom);
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        e_ov = n_ov; e_err = n_err; e_wb_en = n_wb_en; e_data = n_data; e_chk_data = n_chk_data;
        e_pc = n_pc; e_iw = n_iw; e_reg = n_reg;
        n_ov = 0; n_err = 0; n_chk_data = 0;
        e_req = 0; e_ready = 1; e_zero = 0;
        in_valid = 1'b0;
        pc_in = $urandom; iw_in = $urandom; alu_in = $urandom; rs2_data_in = $urandom;
        wb_en_in = 1'($urandom); wb_reg_in = 5'($urandom);
        bus_ack = 1'($urandom); bus_rdata = $urandom;
    endtask

    task automatic set_busy_exp(input op_t o);
        e_req = 1; e_ready = 0;
        e_we = (o.iw[6:0] == OP_STORE);
        e_io = o.alu[31];
        e_addr = o.alu[31:2];
        e_be = m_be(o.iw[14:12], o.alu);
        e_wdata = m_wdata(o.iw[14:12], o.rs2);
    endtask

    task automatic drive_op(input op_t o);
        in_valid = 1'b1;
        pc_in = o.pc; iw_in = o.iw; alu_in = o.alu; rs2_data_in = o.rs2;
        wb_en_in = o.wb_en; wb_reg_in = o.rd;
        e_ready = 1;
        n_pc = o.pc; n_iw = o.iw; n_reg = o.rd;
    endtask

    // Issue one op in an IDLE cycle; ack_at = BUSY cycle (1-based) carrying bus_ack, 0 = never
    task automatic issue(input op_t o, input int ack_at, input logic [31:0] rdata);
        logic [2:0] f3;
        bit ld, st;
        f3 = o.iw[14:12];
        ld = (o.iw[6:0] == OP_LOAD);
        st = (o.iw[6:0] == OP_STORE);
        cap_req_cycles = 0;
        cap_ready_busy = 0;
        drive_op(o);
        if (!(ld || st)) begin
            n_ov = 1; n_err = 0; n_wb_en = o.wb_en; n_data = o.alu; n_chk_data = 1;
            tick();
        end else if (m_misalign(f3, o.alu)) begin
            n_ov = 1; n_err = 1; n_wb_en = 0; n_chk_data = 0;
            tick();
        end else begin
            tick();
            for (int i = 1; i <= int'(MAXW); i++) begin
                set_busy_exp(o);
                in_valid = 1'($urandom);
                bus_ack = (i == ack_at);
                bus_rdata = rdata;
                if (i == 1) begin
                    cap_be = bus_be; cap_wdata = bus_wdata; cap_io = bus_io;
                    cap_addr = bus_addr; cap_we = bus_we;
                end
                if (bus_req) cap_req_cycles++;
                if (in_ready) cap_ready_busy++;
                if (i == ack_at) begin
                    n_ov = 1; n_err = 0; n_wb_en = st ? 1'b0 : o.wb_en;
                    n_data = m_load(rdata, f3, o.alu); n_chk_data = !st;
                    tick();
                    break;
                end
                if (i == int'(MAXW)) begin
                    n_ov = 1; n_err = 1; n_wb_en = 0; n_chk_data = 0;
                    tick();
                    break;
                end
                tick();
            end
        end
        cap_ov = out_valid; cap_err = err_out; cap_data = wb_data_out;
        cap_wb_en = wb_en_out; cap_req_after = bus_req;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(e_ready));
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            chk("err_out", 32'(err_out), 32'(e_err));
            chk("bus_req", 32'(bus_req), 32'(e_req));
            if (e_zero) begin
                chk("rst_pc_out", pc_out, 32'd0);
                chk("rst_iw_out", iw_out, 32'd0);
                chk("rst_wb_en", 32'(wb_en_out), 32'd0);
                chk("rst_wb_reg", 32'(wb_reg_out), 32'd0);
                chk("rst_wb_data", wb_data_out, 32'd0);
                chk("rst_bus_we", 32'(bus_we), 32'd0);
                chk("rst_bus_io", 32'(bus_io), 32'd0);
                chk("rst_bus_be", 32'(bus_be), 32'd0);
                chk("rst_bus_addr", 32'(bus_addr), 32'd0);
                chk("rst_bus_wdata", bus_wdata, 32'd0);
            end
            if (e_req) begin
                chk("bus_we", 32'(bus_we), 32'(e_we));
                chk("bus_io", 32'(bus_io), 32'(e_io));
                chk("bus_addr", 32'(bus_addr), 32'(e_addr));
                if (e_we) begin
                    chk("bus_be", 32'(bus_be), 32'(e_be));
                    chk("bus_wdata", bus_wdata, e_wdata);
                end
            end
            if (e_ov) begin
                chk("wb_en_out", 32'(wb_en_out), 32'(e_wb_en));
                chk("wb_reg_out", 32'(wb_reg_out), 32'(e_reg));
                chk("pc_out", pc_out, e_pc);
                chk("iw_out", iw_out, e_iw);
                if (e_chk_data) chk("wb_data_out", wb_data_out, e_data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        int kind, ack_at;
        logic [6:0] nonmem [4] = '{OP_IMM, 7'b0110011, 7'b0110111, 7'b1101111};

        reset = 1'b1; in_valid = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        pc_in = '0; iw_in = '0; alu_in = '0; rs2_data_in = '0; wb_en_in = 1'b0; wb_reg_in = '0;
        n_pc = '0; n_iw = '0; n_reg = '0; n_data = '0;
        tick();
        chk_en = 1; e_zero = 1; e_ready = 0;
        tick();
        reset = 1'b0;
        e_zero = 1;
        tick();

        // ADDI passes straight through with no bus cycle
        o = mk_op(OP_IMM, 3'b000, 32'h12, 32'h0);
        issue(o, 0, 32'h0);
        chk("addi_ov", 32'(cap_ov), 32'd1);
        chk("addi_data", cap_data, 32'h12);
        chk("addi_no_req", 32'(cap_req_after), 32'd0);

        // LB at 0x103, ack on second BUSY cycle
        o = mk_op(OP_LOAD, 3'b000, 32'h0000_0103, 32'h0);
        issue(o, 2, 32'h80FF_1234);
        chk("lb_data", cap_data, 32'hFFFF_FF80);
        chk("lb_busy_cycles", 32'(cap_req_cycles), 32'd2);
        chk("lb_ready_in_busy", 32'(cap_ready_busy), 32'd0);

        // SH into IO space
        o = mk_op(OP_STORE, 3'b001, 32'h8000_0002, 32'h0000_ABCD);
        issue(o, 1, 32'h0);
        chk("sh_io", 32'(cap_io), 32'd1);
        chk("sh_be", 32'(cap_be), 32'b1100);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_wb_en", 32'(cap_wb_en), 32'd0);

        // LW with no ack times out after MAX_WAIT BUSY cycles
        o = mk_op(OP_LOAD, 3'b010, 32'h0000_2000, 32'h0);
        issue(o, 0, 32'h0);
        chk("to_busy_cycles", 32'(cap_req_cycles), 32'(MAXW));
        chk("to_ov", 32'(cap_ov), 32'd1);
        chk("to_err", 32'(cap_err), 32'd1);
        chk("to_req_dropped", 32'(cap_req_after), 32'd0);

        // Ack on the last allowed BUSY cycle still completes normally
        o = mk_op(OP_LOAD, 3'b100, 32'h0000_0001, 32'h0);
        issue(o, int'(MAXW), 32'h0000_AB00);
        chk("late_ack_err", 32'(cap_err), 32'd0);
        chk("late_ack_data", cap_data, 32'h0000_00AB);

        // Misaligned LW
        o = mk_op(OP_LOAD, 3'b010, 32'h0000_1002, 32'h0);
        issue(o, 1, 32'hDEAD_BEEF);
`ifdef MISALIGN_TRAP_EN
        chk("mis_err", 32'(cap_err), 32'd1);
        chk("mis_no_bus", 32'(cap_req_cycles), 32'd0);
`else
        chk("mis_addr", 32'(cap_addr), 32'h0000_0400);
        chk("mis_data", cap_data, 32'hDEAD_BEEF);
        chk("mis_no_err", 32'(cap_err), 32'd0);
`endif

        // Reset during BUSY, late ack, then an ADDI right away
        o = mk_op(OP_LOAD, 3'b010, 32'h0000_3000, 32'h0);
        drive_op(o);
        tick();
        set_busy_exp(o); bus_ack = 1'b0;
        tick();
        set_busy_exp(o); bus_ack = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; e_zero = 1; bus_ack = 1'b1;
        o = mk_op(OP_IMM, 3'b000, 32'h0000_0077, 32'h0);
        issue(o, 0, 32'h0);
        chk("rst_addi_ov", 32'(cap_ov), 32'd1);
        chk("rst_addi_data", cap_data, 32'h77);
        chk("rst_addi_err", 32'(cap_err), 32'd0);
        tick();

        // Randomized mix
        for (int n = 0; n < 200; n++) begin
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
            kind = int'($urandom_range(0, 9));
            ack_at = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            if (kind < 4)
                o = mk_op(nonmem[$urandom_range(0, 3)], 3'($urandom), $urandom, $urandom);
            else if (kind < 7)
                o = mk_op(OP_LOAD, 3'($urandom), $urandom, $urandom);
            else
                o = mk_op(OP_STORE, 3'($urandom_range(0, 2)), $urandom, $urandom);
            o.wb_en = 1'($urandom);
            issue(o, ack_at, $urandom);
        end
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
